// File: rtl/clu_isolate_pkg.sv
// Shared types and helpers for the cluster AXI isolation controller.
package clu_isolate_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ISOLATED = 2'd2
    } state_t;

    // Width needed to hold 0..max_txns inclusive.
    function automatic int cnt_width(input int max_txns);
        return $clog2(max_txns + 1);
    endfunction

endpackage

// File: rtl/clu_txn_counter.sv
// Saturating outstanding-transaction counter with a sticky underflow flag.
module clu_txn_counter
    import clu_isolate_pkg::*;
#(
    parameter int MaxTxns = 8,
    parameter int CntW    = cnt_width(MaxTxns)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            dec,
    output logic [CntW-1:0] cnt,
    output logic            err
);

    localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);

    // A simultaneous inc and dec is a net no-op, including at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (inc && !dec) begin
            if (cnt != CntMax) begin
                cnt <= cnt + CntW'(1);
            end
        end else if (dec && !inc) begin
            if (cnt != '0) begin
                cnt <= cnt - CntW'(1);
            end else begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clu_isolate_ctrl.sv
// Supervises cluster narrow AXI ports: limits outstanding transactions per port
// and direction, and drains/gates all ports on an isolation request.
module clu_isolate_ctrl
    import clu_isolate_pkg::*;
#(
    parameter int NumPorts = 2,
    parameter int MaxTxns  = 8
) (
    input  logic                soc_clk_i,
    input  logic                rst_i,
    input  logic                isolate_req_i,
    input  logic [NumPorts-1:0] aw_valid_i,
    input  logic [NumPorts-1:0] aw_ready_i,
    input  logic [NumPorts-1:0] ar_valid_i,
    input  logic [NumPorts-1:0] ar_ready_i,
    input  logic [NumPorts-1:0] b_valid_i,
    input  logic [NumPorts-1:0] b_ready_i,
    input  logic [NumPorts-1:0] r_valid_i,
    input  logic [NumPorts-1:0] r_ready_i,
    input  logic [NumPorts-1:0] r_last_i,
    output logic [NumPorts-1:0] aw_gate_o,
    output logic [NumPorts-1:0] ar_gate_o,
    output logic                isolated_o,
    output logic [1:0]          state_o,
    output logic                err_o
);

    localparam int              CntW    = cnt_width(MaxTxns);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxTxns);
    localparam logic [CntW-1:0] CntLast = CntW'(MaxTxns - 1);

    state_t              state_reg, state_next;
    logic                isolated_reg;
    logic [NumPorts-1:0] aw_gate_reg, ar_gate_reg, aw_gate_next, ar_gate_next;
    logic [NumPorts-1:0] aw_pend_reg, ar_pend_reg, aw_pend_next, ar_pend_next;
    logic [NumPorts-1:0] aw_acc, ar_acc, b_evt, r_end;
    logic [NumPorts-1:0] wr_idle, rd_idle, wr_err, rd_err;
    logic                leaving_active, drained;

    assign aw_acc = aw_valid_i & aw_ready_i & ~aw_gate_reg;
    assign ar_acc = ar_valid_i & ar_ready_i & ~ar_gate_reg;
    assign b_evt  = b_valid_i & b_ready_i;
    assign r_end  = r_valid_i & r_ready_i & r_last_i;

    // Gates follow the next state so they drop together with the return to ACTIVE.
    assign leaving_active = (state_next != ST_ACTIVE);

    generate
        for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
            logic [CntW-1:0] wr_cnt, rd_cnt;
            logic            aw_demand, ar_demand, aw_safe, ar_safe;

            clu_txn_counter #(.MaxTxns(MaxTxns), .CntW(CntW)) u_wr_cnt (
                .clk (soc_clk_i),
                .rst (rst_i),
                .inc (aw_acc[gi]),
                .dec (b_evt[gi]),
                .cnt (wr_cnt),
                .err (wr_err[gi])
            );

            clu_txn_counter #(.MaxTxns(MaxTxns), .CntW(CntW)) u_rd_cnt (
                .clk (soc_clk_i),
                .rst (rst_i),
                .inc (ar_acc[gi]),
                .dec (r_end[gi]),
                .cnt (rd_cnt),
                .err (rd_err[gi])
            );

            assign wr_idle[gi] = (wr_cnt == '0);
            assign rd_idle[gi] = (rd_cnt == '0);

            // The limiter term anticipates the accept that fills the last slot.
            assign aw_demand = leaving_active || (wr_cnt == CntMax) ||
                               (aw_acc[gi] && !b_evt[gi] && (wr_cnt == CntLast));
            assign ar_demand = leaving_active || (rd_cnt == CntMax) ||
                               (ar_acc[gi] && !r_end[gi] && (rd_cnt == CntLast));

            // Never close on a handshake that has started but not completed.
            assign aw_safe = !(aw_pend_reg[gi] && !aw_acc[gi]) && !(aw_valid_i[gi] && !aw_ready_i[gi]);
            assign ar_safe = !(ar_pend_reg[gi] && !ar_acc[gi]) && !(ar_valid_i[gi] && !ar_ready_i[gi]);

            assign aw_gate_next[gi] = aw_demand && (aw_gate_reg[gi] || aw_safe);
            assign ar_gate_next[gi] = ar_demand && (ar_gate_reg[gi] || ar_safe);

            assign aw_pend_next[gi] = (aw_valid_i[gi] && !aw_ready_i[gi] && !aw_gate_reg[gi]) ||
                                      (aw_pend_reg[gi] && !aw_acc[gi]);
            assign ar_pend_next[gi] = (ar_valid_i[gi] && !ar_ready_i[gi] && !ar_gate_reg[gi]) ||
                                      (ar_pend_reg[gi] && !ar_acc[gi]);
        end
    endgenerate

    assign drained = (&aw_gate_reg) && (&ar_gate_reg) && (&wr_idle) && (&rd_idle) &&
                     !(|aw_pend_reg) && !(|ar_pend_reg);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_ACTIVE: begin
                if (isolate_req_i) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!isolate_req_i) state_next = ST_ACTIVE;
                else if (drained)   state_next = ST_ISOLATED;
            end
            ST_ISOLATED: begin
                if (!isolate_req_i) state_next = ST_ACTIVE;
            end
            default: state_next = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge soc_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= ST_ACTIVE;
            isolated_reg <= 1'b0;
            aw_gate_reg  <= '0;
            ar_gate_reg  <= '0;
            aw_pend_reg  <= '0;
            ar_pend_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            isolated_reg <= (state_next == ST_ISOLATED);
            aw_gate_reg  <= aw_gate_next;
            ar_gate_reg  <= ar_gate_next;
            aw_pend_reg  <= aw_pend_next;
            ar_pend_reg  <= ar_pend_next;
        end
    end

    assign aw_gate_o  = aw_gate_reg;
    assign ar_gate_o  = ar_gate_reg;
    assign isolated_o = isolated_reg;
    assign state_o    = state_reg;
    assign err_o      = |{wr_err, rd_err};

endmodule
